// File: rtl/rtc_bus_sequencer.sv
// Phase-timed bus sequencer for a multiplexed-AD RTC: address phase, then data
// write or read phase, with every output registered from the next-state value.
module rtc_bus_sequencer #(
    parameter int unsigned T_PH = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] data_wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       listo,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_SET = 3'd1,
        A_STB = 3'd2,
        A_HLD = 3'd3,
        D_SET = 3'd4,
        D_STB = 3'd5,
        D_HLD = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [7:0] RELOAD = 8'(T_PH - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] data_rd_q, data_rd_d;

    logic [7:0] ad_out_d;
    logic       ad_oe_d, cs_n_d, ad_n_d, rd_n_d, wr_n_d, busy_d, listo_d;

    // Next state, phase counter and transaction latches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        data_rd_d = data_rd_q;
        case (state_q)
            IDLE: begin
                if (inicio) begin
                    state_d = A_SET;
                    cnt_d   = RELOAD;
                    rw_d    = rw;
                    addr_d  = addr;
                    data_d  = data_wr;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                if (cnt_q == 8'd0) begin
                    state_d = state_t'(state_q + 3'd1);
                    cnt_d   = (state_q == D_HLD) ? 8'd0 : RELOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase
        // Sample the bus on the last cycle of the read strobe.
        if (state_q == D_STB && cnt_q == 8'd0 && rw_q)
            data_rd_d = ad_in;
    end

    // Output decode from the state being entered, so outputs change with state.
    always_comb begin
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        listo_d  = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_d)
            A_SET, A_HLD: begin
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            A_STB: begin
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
            end
            D_SET, D_HLD: begin
                if (!rw_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_d;
                end
            end
            D_STB: begin
                cs_n_d = 1'b0;
                if (rw_d) begin
                    rd_n_d = 1'b0;
                end else begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_d;
                    wr_n_d   = 1'b0;
                end
            end
            DONE:    listo_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            rw_q      <= 1'b0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            data_rd_q <= 8'h00;
            ad_out    <= 8'h00;
            ad_oe     <= 1'b0;
            cs_n      <= 1'b1;
            ad_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            busy      <= 1'b0;
            listo     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            data_rd_q <= data_rd_d;
            ad_out    <= ad_out_d;
            ad_oe     <= ad_oe_d;
            cs_n      <= cs_n_d;
            ad_n      <= ad_n_d;
            rd_n      <= rd_n_d;
            wr_n      <= wr_n_d;
            busy      <= busy_d;
            listo     <= listo_d;
        end
    end

    assign data_rd     = data_rd_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: one instance at T_PH=10 for write, read,
// abort and input-change cases, one at T_PH=1 for back-to-back transactions.
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // T_PH = 10 instance
    logic       inicio, rw;
    logic [7:0] addr, data_wr, ad_in;
    logic [7:0] ad_out, data_rd;
    logic       ad_oe, cs_n, ad_n, rd_n, wr_n, busy, listo;
    logic [2:0] dbg_state;

    // T_PH = 1 instance
    logic       inicio1, rw1;
    logic [7:0] addr1, data_wr1, ad_in1;
    logic [7:0] ad_out1, data_rd1;
    logic       ad_oe1, cs_n1, ad_n1, rd_n1, wr_n1, busy1, listo1;
    logic [2:0] dbg_state1;

    int n_checks = 0;
    int n_errors = 0;

    rtc_bus_sequencer #(.T_PH(10)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .rw(rw), .addr(addr),
        .data_wr(data_wr), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n), .data_rd(data_rd),
        .busy(busy), .listo(listo), .dbg_state_o(dbg_state)
    );

    rtc_bus_sequencer #(.T_PH(1)) dut1 (
        .clk(clk), .rst(rst), .inicio(inicio1), .rw(rw1), .addr(addr1),
        .data_wr(data_wr1), .ad_in(ad_in1), .ad_out(ad_out1), .ad_oe(ad_oe1),
        .cs_n(cs_n1), .ad_n(ad_n1), .rd_n(rd_n1), .wr_n(wr_n1), .data_rd(data_rd1),
        .busy(busy1), .listo(listo1), .dbg_state_o(dbg_state1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [14:0] obs_vec();
        return {listo, busy, ad_oe, ad_out, cs_n, ad_n, rd_n, wr_n};
    endfunction

    // p: 0..5 = A_SET..D_HLD, 6 = DONE, 7 = IDLE
    function automatic logic [14:0] exp_vec(input int p, input logic rd,
                                            input logic [7:0] a, input logic [7:0] d);
        logic       oe, cs, an, rn, wn, li, bz;
        logic [7:0] o;
        oe = 1'b0; o = 8'h00; cs = 1'b1; an = 1'b1; rn = 1'b1; wn = 1'b1;
        li = 1'b0; bz = 1'b1;
        case (p)
            0, 2: begin oe = 1'b1; o = a; end
            1:    begin oe = 1'b1; o = a; cs = 1'b0; an = 1'b0; end
            3, 5: if (!rd) begin oe = 1'b1; o = d; end
            4: begin
                cs = 1'b0;
                if (rd) rn = 1'b0;
                else begin oe = 1'b1; o = d; wn = 1'b0; end
            end
            6:       li = 1'b1;
            default: bz = 1'b0;
        endcase
        return {li, bz, oe, o, cs, an, rn, wn};
    endfunction

    // One transaction on the T_PH=10 instance with a start-register model:
    // inicio stays high until listo is seen.
    task automatic run_txn(input logic is_read, input logic [7:0] a, input logic [7:0] d,
                           input bit mid_change, input logic [7:0] rd_before,
                           input logic [7:0] rd_after);
        int p;
        rw = is_read; addr = a; data_wr = d; inicio = 1'b1; ad_in = 8'hAA;
        for (int k = 1; k <= 62; k++) begin
            tick();
            p = (k <= 60) ? (k - 1) / 10 : (k == 61 ? 6 : 7);
            chk($sformatf("%s_vec_k%0d", is_read ? "rd" : "wr", k), 32'(obs_vec()),
                32'(exp_vec(p, is_read, a, d)));
            if (k == 50) chk("data_rd_before_capture", 32'(data_rd), 32'(rd_before));
            if (k == 51) chk("data_rd_after_capture", 32'(data_rd), 32'(rd_after));
            if (listo) inicio = 1'b0;
            if (mid_change && k == 45) begin
                addr = 8'h7F; data_wr = 8'h00; rw = ~rw;
            end
            ad_in = (k == 50) ? 8'h59 : 8'hAA;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_after_txn", {30'd0, busy, listo}, 32'd0);
        end
    endtask

    initial begin
        int listo_seen;
        logic [3:0] exp4;
        rst = 1'b1;
        inicio = 1'b0; rw = 1'b0; addr = 8'h00; data_wr = 8'h00; ad_in = 8'h00;
        inicio1 = 1'b0; rw1 = 1'b0; addr1 = 8'h10; data_wr1 = 8'h20; ad_in1 = 8'h00;
        repeat (3) tick();
        chk("reset_vec", 32'(obs_vec()), 32'({1'b0, 1'b0, 1'b0, 8'h00, 4'b1111}));
        chk("reset_data_rd", 32'(data_rd), 32'h00);
        rst = 1'b0;
        tick();
        chk("idle_no_inicio", {30'd0, busy, listo}, 32'd0);

        // Read: addr 22, bus value 59 captured at the end of the read strobe
        run_txn(1'b1, 8'h22, 8'h00, 1'b0, 8'h00, 8'h59);
        chk("data_rd_after_read", 32'(data_rd), 32'h59);

        // Write: addr 21 data 35, inputs changed during D_STB; data_rd untouched
        run_txn(1'b0, 8'h21, 8'h35, 1'b1, 8'h59, 8'h59);
        chk("data_rd_after_write", 32'(data_rd), 32'h59);

        // Reset in the 5th cycle of D_STB with inicio still high
        rw = 1'b0; addr = 8'h21; data_wr = 8'h35; inicio = 1'b1;
        for (int k = 1; k <= 45; k++) tick();
        chk("abort_pre_vec", 32'(obs_vec()), 32'(exp_vec(4, 1'b0, 8'h21, 8'h35)));
        rst = 1'b1;
        tick();
        chk("abort_vec", 32'(obs_vec()), 32'({1'b0, 1'b0, 1'b0, 8'h00, 4'b1111}));
        chk("abort_data_rd", 32'(data_rd), 32'h00);
        rst = 1'b0; inicio = 1'b0;
        listo_seen = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (listo || busy) listo_seen++;
        end
        chk("abort_no_listo", 32'(listo_seen), 32'd0);

        // T_PH=1, inicio held high: 7-cycle transactions, one IDLE cycle between
        inicio1 = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            int j;
            tick();
            j = (k - 1) % 8;
            exp4 = {j != 7, j == 6, j != 1, j != 4};
            chk($sformatf("tph1_k%0d", k), {28'd0, busy1, listo1, ad_n1, wr_n1}, {28'd0, exp4});
        end
        inicio1 = 1'b0;
        tick();
        tick();
        chk("tph1_stop", {30'd0, busy1, listo1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Strobe safety rules on both instances at every sample point.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_wr_exclusive", {30'd0, rd_n, wr_n} & 32'h3, ((!rd_n) ? 32'h1 : 32'h0) | {30'd0, rd_n, wr_n} & 32'h2 | (rd_n ? {31'd0, wr_n} : 32'h1));
            chk("oe_off_when_read", {31'd0, ad_oe & ~rd_n}, 32'd0);
            chk("out_zero_when_off", {24'd0, ad_oe ? 8'h00 : ad_out}, 32'd0);
            chk("oe_off_when_read_t1", {31'd0, ad_oe1 & ~rd_n1}, 32'd0);
            chk("out_zero_when_off_t1", {24'd0, ad_oe1 ? 8'h00 : ad_out1}, 32'd0);
        end
    end

endmodule
